// File: rtl/primal_math_arbiter.sv
// Round-robin arbiter sharing one primal_math_engine between NUM_REQ requesters.
// Each operation latches the winner's operands, clears the engine (clearing its
// sticky valid), pulses compute, waits for valid or a timeout, then returns a
// tagged one-cycle response.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/op/prime_a/b    per-requester level request and operands (packed slices)
//   req_ack                   one-cycle pulse when requester i's operands are latched
//   busy                      high in every state except idle
//   rsp_*                     one-cycle tagged response (data zeroed on timeout)
//   eng_prime_a/b, eng_op     latched operands driven to the engine
//   eng_compute, eng_clear    one-cycle engine start / clear pulses
//   eng_result/t1_rem/valid/violation   engine outputs
module primal_math_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [2*NUM_REQ-1:0]          req_op,
  input  logic [32*NUM_REQ-1:0]         req_prime_a,
  input  logic [32*NUM_REQ-1:0]         req_prime_b,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          busy,
  output logic                          rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [31:0]                   rsp_result,
  output logic [31:0]                   rsp_remainder,
  output logic                          rsp_violation,
  output logic                          rsp_timeout,
  output logic [31:0]                   eng_prime_a,
  output logic [31:0]                   eng_prime_b,
  output logic [1:0]                    eng_op,
  output logic                          eng_compute,
  output logic                          eng_clear,
  input  logic [31:0]                   eng_result,
  input  logic [31:0]                   eng_t1_rem,
  input  logic                          eng_valid,
  input  logic                          eng_violation
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StClear, StIssue, StWait, StResp} state_e;

  state_e          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [15:0]     wait_cnt;

  logic            found;
  logic [ID_W-1:0] win_idx;
  logic [1:0]      win_op;
  logic [31:0]     win_a;
  logic [31:0]     win_b;

  // Round-robin pick: first pass covers indices at or above rr_ptr, second pass
  // wraps to the low indices.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && req_valid[j] && (ID_W'(j) >= rr_ptr)) begin
        found   = 1'b1;
        win_idx = ID_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && req_valid[j]) begin
        found   = 1'b1;
        win_idx = ID_W'(j);
      end
    end
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == win_idx) begin
        win_op = req_op[2*j +: 2];
        win_a  = req_prime_a[32*j +: 32];
        win_b  = req_prime_b[32*j +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      rr_ptr        <= '0;
      winner        <= '0;
      wait_cnt      <= '0;
      req_ack       <= '0;
      busy          <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_remainder <= '0;
      rsp_violation <= 1'b0;
      rsp_timeout   <= 1'b0;
      eng_prime_a   <= '0;
      eng_prime_b   <= '0;
      eng_op        <= '0;
      eng_compute   <= 1'b0;
      eng_clear     <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one state.
      req_ack     <= '0;
      eng_clear   <= 1'b0;
      eng_compute <= 1'b0;
      rsp_valid   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (found) begin
            winner           <= win_idx;
            eng_op           <= win_op;
            eng_prime_a      <= win_a;
            eng_prime_b      <= win_b;
            req_ack[win_idx] <= 1'b1;
            eng_clear        <= 1'b1;
            busy             <= 1'b1;
            state            <= StClear;
          end
        end
        StClear: begin
          eng_compute <= 1'b1;
          state       <= StIssue;
        end
        StIssue: begin
          wait_cnt <= '0;
          state    <= StWait;
        end
        StWait: begin
          // Valid wins over timeout, so valid on the final count is a success.
          if (eng_valid) begin
            rsp_result    <= eng_result;
            rsp_remainder <= eng_t1_rem;
            rsp_violation <= eng_violation;
            rsp_timeout   <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_id        <= winner;
            state         <= StResp;
          end else if (wait_cnt == WAIT_LAST) begin
            rsp_result    <= '0;
            rsp_remainder <= '0;
            rsp_violation <= 1'b0;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            rsp_id        <= winner;
            state         <= StResp;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        StResp: begin
          rr_ptr <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
          busy   <= 1'b0;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_primal_math_arbiter.sv
// Self-checking bench for primal_math_arbiter with a behavioural engine model.
module tb_primal_math_arbiter;

  localparam int NumReq  = 4;
  localparam int Timeout = 4;
  localparam int IdW     = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NumReq-1:0]       req_valid;
  logic [2*NumReq-1:0]     req_op;
  logic [32*NumReq-1:0]    req_prime_a;
  logic [32*NumReq-1:0]    req_prime_b;
  logic [NumReq-1:0]       req_ack;
  logic                    busy;
  logic                    rsp_valid;
  logic [IdW-1:0]          rsp_id;
  logic [31:0]             rsp_result;
  logic [31:0]             rsp_remainder;
  logic                    rsp_violation;
  logic                    rsp_timeout;
  logic [31:0]             eng_prime_a;
  logic [31:0]             eng_prime_b;
  logic [1:0]              eng_op;
  logic                    eng_compute;
  logic                    eng_clear;
  logic [31:0]             eng_result;
  logic [31:0]             eng_t1_rem;
  logic                    eng_valid;
  logic                    eng_violation;

  int n_checks = 0;
  int n_pass   = 0;
  int ptr_m    = 0;  // model round-robin pointer

  always #5 clk = ~clk;

  primal_math_arbiter #(
    .NUM_REQ        (NumReq),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_op        (req_op),
    .req_prime_a   (req_prime_a),
    .req_prime_b   (req_prime_b),
    .req_ack       (req_ack),
    .busy          (busy),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_remainder (rsp_remainder),
    .rsp_violation (rsp_violation),
    .rsp_timeout   (rsp_timeout),
    .eng_prime_a   (eng_prime_a),
    .eng_prime_b   (eng_prime_b),
    .eng_op        (eng_op),
    .eng_compute   (eng_compute),
    .eng_clear     (eng_clear),
    .eng_result    (eng_result),
    .eng_t1_rem    (eng_t1_rem),
    .eng_valid     (eng_valid),
    .eng_violation (eng_violation)
  );

  // Bench engine semantics: 00 add, 01 multiply, 10 subtract, 11 xor.
  function automatic logic [31:0] f_result(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a * b;
      2'b10:   return a - b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [31:0] f_rem(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ? 32'd0 : a % b;
  endfunction

  function automatic int model_winner(input logic [NumReq-1:0] m, input int ptr);
    for (int k = 0; k < NumReq; k++) begin
      if (m[(ptr + k) % NumReq]) return (ptr + k) % NumReq;
    end
    return -1;
  endfunction

  // Engine model: reset by rst or eng_clear, valid appears eng_latency cycles after compute.
  int unsigned eng_latency = 2;
  bit          eng_never   = 1'b0;
  bit          eng_viol_on = 1'b0;
  bit          eng_inject  = 1'b0;
  int unsigned e_cnt;
  logic [1:0]  e_op;
  logic [31:0] e_a, e_b;

  always @(posedge clk) begin
    if (rst || eng_clear) begin
      eng_valid <= 1'b0; eng_result <= '0; eng_t1_rem <= '0; eng_violation <= 1'b0;
      e_cnt <= 0;
    end else if (eng_inject) begin
      eng_valid <= 1'b1; eng_result <= 32'hdead_beef; eng_t1_rem <= 32'h1234;
      eng_violation <= 1'b1;
    end else if (eng_compute) begin
      e_cnt <= eng_latency; e_op <= eng_op; e_a <= eng_prime_a; e_b <= eng_prime_b;
    end else if (e_cnt != 0) begin
      e_cnt <= e_cnt - 1;
      if (e_cnt == 1 && !eng_never) begin
        eng_valid     <= 1'b1;
        eng_result    <= f_result(e_op, e_a, e_b);
        eng_t1_rem    <= f_rem(e_a, e_b);
        eng_violation <= eng_viol_on;
      end
    end
  end

  task automatic set_slot(input int i, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    req_op[2*i +: 2]       = op;
    req_prime_a[32*i +: 32] = a;
    req_prime_b[32*i +: 32] = b;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; ptr_m = 0;
  endtask

  task automatic wait_ack(output int id, output bit ok);
    int c;
    ok = 1'b0; id = -1; c = 0;
    while (!ok && c < 20) begin
      @(negedge clk); c++;
      if (req_ack != 0) begin
        ok = 1'b1;
        for (int i = 0; i < NumReq; i++) if (req_ack[i]) id = i;
      end
    end
  endtask

  // Returns at the negedge inside the response cycle; cyc counts negedges waited.
  task automatic wait_rsp(output bit ok, output int cyc, output int acks);
    ok = 1'b0; cyc = 0; acks = 0;
    while (!ok && cyc < 40) begin
      @(negedge clk); cyc++;
      if (req_ack != 0) acks++;
      if (rsp_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; req_op = '0; req_prime_a = '0; req_prime_b = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    n_checks++; if (req_ack !== '0) $display("FAIL reset_ack: got %b want 0", req_ack);
    else n_pass++;
    n_checks++; if ({rsp_valid, rsp_timeout, rsp_violation, eng_compute, eng_clear} !== '0)
      $display("FAIL reset_strobes: got %b want 0",
               {rsp_valid, rsp_timeout, rsp_violation, eng_compute, eng_clear});
    else n_pass++;
    n_checks++; if ({rsp_result, rsp_remainder, eng_prime_a, eng_prime_b} !== '0)
      $display("FAIL reset_data: got %h want 0",
               {rsp_result, rsp_remainder, eng_prime_a, eng_prime_b});
    else n_pass++;
    req_valid = '0; rst = 1'b0; ptr_m = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int id, cyc, acks; bit ok;
    eng_latency = 2;
    set_slot(0, 2'b01, 32'd3, 32'd5);
    req_valid = 4'b0001;
    wait_ack(id, ok);
    n_checks++; if (!ok || id != 0 || req_ack !== 4'b0001)
      $display("FAIL single_ack: got ok=%0d ack=%b want ack=0001", ok, req_ack);
    else n_pass++;
    n_checks++; if (eng_clear !== 1'b1 || busy !== 1'b1 || eng_prime_a !== 32'd3)
      $display("FAIL single_clear: got clr=%b busy=%b a=%0d want 1 1 3", eng_clear, busy,
               eng_prime_a);
    else n_pass++;
    req_valid = '0;
    @(negedge clk);
    n_checks++; if (eng_compute !== 1'b1 || req_ack !== '0 || eng_clear !== 1'b0)
      $display("FAIL single_compute: got cmp=%b ack=%b clr=%b want 1 0 0", eng_compute,
               req_ack, eng_clear);
    else n_pass++;
    wait_rsp(ok, cyc, acks);
    n_checks++; if (!ok || rsp_id !== 2'd0 || rsp_result !== 32'd15 || rsp_remainder !== 32'd3
                    || rsp_timeout !== 1'b0)
      $display("FAIL single_rsp: got ok=%0d id=%0d res=%0d rem=%0d to=%b want 1 0 15 3 0",
               ok, rsp_id, rsp_result, rsp_remainder, rsp_timeout);
    else n_pass++;
    if (ok) ptr_m = 1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_idle: got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int id, cyc, acks, w; bit ok, rok;
    logic [31:0] a [NumReq];
    logic [31:0] b [NumReq];
    apply_reset();
    eng_latency = 1;
    for (int i = 0; i < NumReq; i++) begin
      a[i] = $urandom_range(1, 1 << 20); b[i] = $urandom_range(1, 1 << 20);
      set_slot(i, 2'b00, a[i], b[i]);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w = model_winner(req_valid, ptr_m);
      wait_ack(id, ok);
      n_checks++; if (!ok || id != w)
        $display("FAIL rr_ack%0d: got ok=%0d id=%0d want %0d", k, ok, id, w);
      else n_pass++;
      @(negedge clk);
      wait_rsp(rok, cyc, acks);
      n_checks++; if (!rok || int'(rsp_id) != w || acks != 0 || rsp_result !== a[w] + b[w])
        $display("FAIL rr_rsp%0d: got ok=%0d id=%0d acks=%0d res=%h want id=%0d acks=0 res=%h",
                 k, rok, rsp_id, acks, rsp_result, w, a[w] + b[w]);
      else n_pass++;
      ptr_m = (w + 1) % NumReq;
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  // Runs one op on the given mask and checks winner, latency and payload.
  task automatic test_timing(input string tag, input logic [NumReq-1:0] mask,
                             input int unsigned lat, input bit never);
    int id, cyc, acks, w, want_cyc; bit ok, rok, want_to;
    logic [1:0] op; logic [31:0] a, b;
    op = 2'($urandom); a = $urandom; b = $urandom_range(1, 999);
    w = model_winner(mask, ptr_m);
    set_slot(w, op, a, b);
    eng_latency = lat; eng_never = never;
    want_to  = never || (lat >= Timeout);
    want_cyc = want_to ? Timeout + 1 : int'(lat) + 2;
    req_valid = mask;
    wait_ack(id, ok);
    req_valid = '0;
    n_checks++; if (!ok || id != w) $display("FAIL %s_ack: got %0d want %0d", tag, id, w);
    else n_pass++;
    @(negedge clk);
    wait_rsp(rok, cyc, acks);
    n_checks++; if (!rok || cyc != want_cyc || rsp_timeout !== want_to)
      $display("FAIL %s_wait: got ok=%0d cyc=%0d to=%b want cyc=%0d to=%b", tag, rok, cyc,
               rsp_timeout, want_cyc, want_to);
    else n_pass++;
    n_checks++;
    if (want_to ? ({rsp_result, rsp_remainder, rsp_violation} !== '0)
                : (rsp_result !== f_result(op, a, b) || rsp_remainder !== f_rem(a, b)))
      $display("FAIL %s_data: got res=%h rem=%h to=%b", tag, rsp_result, rsp_remainder,
               want_to);
    else n_pass++;
    ptr_m = (w + 1) % NumReq;
    eng_never = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    test_timing("timeout", 4'b0010, 2, 1'b1);
    test_timing("last_count", 4'b0100, Timeout - 1, 1'b0);
    test_timing("one_late", 4'b1000, Timeout, 1'b0);
  endtask

  task automatic test_stale_valid();
    eng_inject = 1'b1;
    @(negedge clk);
    eng_inject = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (eng_valid !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL stale_idle: got ev=%b busy=%b rv=%b want 1 0 0", eng_valid, busy,
               rsp_valid);
    else n_pass++;
    test_timing("stale", 4'b0011, 2, 1'b0);
  endtask

  task automatic test_violation();
    int id, cyc, acks, w; bit ok, rok;
    logic [31:0] a, b;
    a = $urandom; b = $urandom_range(1, 1 << 16);
    w = model_winner(4'b1000, ptr_m);
    set_slot(3, 2'b11, a, b);
    eng_viol_on = 1'b1; eng_latency = 1;
    req_valid = 4'b1000;
    wait_ack(id, ok);
    req_valid = '0;
    @(negedge clk);
    wait_rsp(rok, cyc, acks);
    n_checks++; if (!ok || !rok || rsp_violation !== 1'b1 || rsp_result !== (a ^ b)
                    || int'(rsp_id) != w)
      $display("FAIL violation: got ok=%0d viol=%b res=%h id=%0d want 1 %h %0d", rok,
               rsp_violation, rsp_result, rsp_id, a ^ b, w);
    else n_pass++;
    ptr_m = (w + 1) % NumReq;
    eng_viol_on = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    int id, cyc, acks, w, seen; bit ok;
    test_timing("pre_rst", 4'b0100, 1, 1'b0);  // model pointer now 3
    eng_never = 1'b1;
    req_valid = 4'b0100;
    wait_ack(id, ok);
    req_valid = '0;
    repeat (3) @(negedge clk);  // issue, wait 0, wait 1
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || eng_compute !== 1'b0)
      $display("FAIL rst_wait: got busy=%b rv=%b cmp=%b want 0 0 0", busy, rsp_valid,
               eng_compute);
    else n_pass++;
    rst = 1'b0; eng_never = 1'b0; ptr_m = 0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    n_checks++; if (seen != 0) $display("FAIL rst_quiet: got %0d active cycles want 0", seen);
    else n_pass++;
    w = model_winner(4'b1100, ptr_m);
    eng_latency = 1;
    req_valid = 4'b1100;
    wait_ack(id, ok);
    req_valid = '0;
    n_checks++; if (!ok || id != w) $display("FAIL rst_regrant: got %0d want %0d", id, w);
    else n_pass++;
    @(negedge clk);
    wait_rsp(ok, cyc, acks);
    n_checks++; if (!ok || int'(rsp_id) != w)
      $display("FAIL rst_rsp: got ok=%0d id=%0d want %0d", ok, rsp_id, w);
    else n_pass++;
    ptr_m = (w + 1) % NumReq;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [NumReq-1:0] mask;
      logic [1:0] op; logic [31:0] a, b;
      int id, cyc, acks, w, want_cyc; bit ok, rok, never, want_to; int unsigned lat;
      mask = NumReq'($urandom_range(1, 15));
      for (int i = 0; i < NumReq; i++) set_slot(i, 2'($urandom), $urandom, $urandom_range(0, 999));
      never = ($urandom_range(0, 7) == 0);
      lat   = $urandom_range(1, Timeout);
      eng_never = never; eng_latency = lat;
      w  = model_winner(mask, ptr_m);
      op = req_op[2*w +: 2]; a = req_prime_a[32*w +: 32]; b = req_prime_b[32*w +: 32];
      want_to  = never || (lat >= Timeout);
      want_cyc = want_to ? Timeout + 1 : int'(lat) + 2;
      req_valid = mask;
      wait_ack(id, ok);
      n_checks++; if (!ok || id != w)
        $display("FAIL rand%0d_ack: got ok=%0d id=%0d want %0d", it, ok, id, w);
      else n_pass++;
      // Inputs change while busy; the latched operands must be unaffected.
      req_valid = NumReq'($urandom);
      for (int i = 0; i < NumReq; i++) set_slot(i, 2'($urandom), $urandom, $urandom);
      @(negedge clk);
      wait_rsp(rok, cyc, acks);
      n_checks++;
      if (!rok || int'(rsp_id) != w || cyc != want_cyc || rsp_timeout !== want_to || acks != 0
          || (want_to ? ({rsp_result, rsp_remainder} !== '0)
                      : (rsp_result !== f_result(op, a, b) || rsp_remainder !== f_rem(a, b))))
        $display("FAIL rand%0d_rsp: got id=%0d cyc=%0d to=%b res=%h rem=%h want id=%0d cyc=%0d to=%b",
                 it, rsp_id, cyc, rsp_timeout, rsp_result, rsp_remainder, w, want_cyc, want_to);
      else n_pass++;
      ptr_m = (w + 1) % NumReq;
    end
    req_valid = '0; eng_never = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_stale_valid();
    test_violation();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
